// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use bubble, operand forwarding selects,
// memory-not-ready freeze with timeout, and a saturating stall-cycle counter.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load_instr,
    input  logic [4:0]       mem_rd,
    input  logic             mem_rf_enable,
    input  logic             mem_enable,
    input  logic             mem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_rf_enable,
    output logic             pc_ld,
    output logic             npc_ld,
    output logic             ifid_ld,
    output logic             idex_ld,
    output logic             exmem_ld,
    output logic             memwb_ld,
    output logic             cu_mux_s,
    output logic [1:0]       pa_sel,
    output logic [1:0]       pb_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout_err
);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    state_e           r_state, w_state_next;
    logic [7:0]       r_wait_cnt, w_wait_cnt_next;
    logic [CNT_W-1:0] r_stall_count;
    logic             r_timeout_err;

    logic w_ex_rs, w_mem_rs, w_wb_rs, w_ex_rt, w_mem_rt, w_wb_rt;
    logic w_load_use, w_mem_stall, w_freeze;
    logic w_front_ld, w_back_ld, w_cu_mux_s;

    // Register 0 is hard-wired, so it never produces a dependency
    assign w_ex_rs  = id_uses_rs & ex_rf_enable  & (ex_rd  == id_rs) & (id_rs != 5'd0);
    assign w_mem_rs = id_uses_rs & mem_rf_enable & (mem_rd == id_rs) & (id_rs != 5'd0);
    assign w_wb_rs  = id_uses_rs & wb_rf_enable  & (wb_rd  == id_rs) & (id_rs != 5'd0);
    assign w_ex_rt  = id_uses_rt & ex_rf_enable  & (ex_rd  == id_rt) & (id_rt != 5'd0);
    assign w_mem_rt = id_uses_rt & mem_rf_enable & (mem_rd == id_rt) & (id_rt != 5'd0);
    assign w_wb_rt  = id_uses_rt & wb_rf_enable  & (wb_rd  == id_rt) & (id_rt != 5'd0);

    assign w_load_use  = ex_load_instr & (w_ex_rs | w_ex_rt);
    assign w_mem_stall = mem_enable & ~mem_ready;
    assign w_freeze    = (r_state == StMemWait) ? ~mem_ready : w_mem_stall;

    always_comb begin
        pa_sel = 2'b00;
        if (w_ex_rs)       pa_sel = 2'b01;
        else if (w_mem_rs) pa_sel = 2'b10;
        else if (w_wb_rs)  pa_sel = 2'b11;
        pb_sel = 2'b00;
        if (w_ex_rt)       pb_sel = 2'b01;
        else if (w_mem_rt) pb_sel = 2'b10;
        else if (w_wb_rt)  pb_sel = 2'b11;
    end

    always_comb begin
        w_front_ld = 1'b1;
        w_back_ld  = 1'b1;
        w_cu_mux_s = 1'b0;
        if (reset) begin
            w_front_ld = 1'b0;
            w_back_ld  = 1'b0;
            w_cu_mux_s = 1'b1;
        end else begin
            case (r_state)
                StRun, StMemWait: begin
                    if (w_freeze) begin
                        w_front_ld = 1'b0;
                        w_back_ld  = 1'b0;
                    end else if (w_load_use) begin
                        w_front_ld = 1'b0;
                        w_cu_mux_s = 1'b1;
                    end
                end
                default: begin
                    w_front_ld = 1'b0;
                    w_back_ld  = 1'b0;
                    w_cu_mux_s = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            StRun: begin
                if (w_mem_stall) begin
                    w_state_next    = StMemWait;
                    w_wait_cnt_next = 8'd1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    w_state_next    = StRun;
                    w_wait_cnt_next = 8'd0;
                end else if (r_wait_cnt == TimeoutCnt) begin
                    w_state_next = StError;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end
            StError: w_state_next = StError;
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StRun;
            r_wait_cnt    <= 8'd0;
            r_stall_count <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_timeout_err <= (w_state_next == StError);
            if (!w_front_ld && (r_state != StError) && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign pc_ld           = w_front_ld;
    assign npc_ld          = w_front_ld;
    assign ifid_ld         = w_front_ld;
    assign idex_ld         = w_back_ld;
    assign exmem_ld        = w_back_ld;
    assign memwb_ld        = w_back_ld;
    assign cu_mux_s        = w_cu_mux_s;
    assign stall_count     = r_stall_count;
    assign mem_timeout_err = r_timeout_err;

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the five-stage PPU. It sits between the ID stage (control unit and NOP mux) and the stage registers. It detects load-use hazards and inserts one bubble through the control-unit mux `S` while freezing PC, nPC and IF/ID. It generates forwarding selects for operands PA/PB and freezes the whole pipeline while the data memory is not ready. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: consecutive memory not-ready cycles that trigger the ERROR state; legal range 1..255.
- `CNT_W`, 16: width of `stall_count`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `id_rs`, `id_rt` input 5 each: ID-stage source register fields.
- `id_uses_rs`, `id_uses_rt` input 1 each: the ID instruction reads that source.
- `ex_rd` input 5: destination register in ID/EX.
- `ex_rf_enable`, `ex_load_instr` input 1 each: EX-stage RF write enable and load flag.
- `mem_rd` input 5: destination register in EX/MEM.
- `mem_rf_enable`, `mem_enable`, `mem_ready` input 1 each: MEM-stage RF write enable, memory access active, and memory ready.
- `wb_rd` input 5: destination register in MEM/WB.
- `wb_rf_enable` input 1: WB-stage RF write enable.
- `pc_ld`, `npc_ld`, `ifid_ld` output 1 each: load enables for PC, nPC and IF/ID.
- `idex_ld`, `exmem_ld`, `memwb_ld` output 1 each: stage-register load enables.
- `cu_mux_s` output 1: select for the control-unit mux; 1 forces all 22 control bits to 0 (NOP).
- `pa_sel`, `pb_sel` output 2 each: operand source. 00 = register file, 01 = EX result, 10 = MEM result (including load data), 11 = WB result.
- `stall_count` output CNT_W: saturating count of stalled cycles.
- `mem_timeout_err` output 1: sticky error flag.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Internal `wait_cnt` is 8 bits.
- Match rule for source s (rs or rt): a stage matches when `id_uses_s` is 1, that stage's rf_enable is 1, that stage's rd equals s, and s is not 0. Register 0 never matches.
- Forwarding is combinational and independent of state. `pa_sel` uses rs and `pb_sel` uses rt. Priority is EX (01), then MEM (10), then WB (11), else 00.
- Load-use hazard: `ex_load_instr` is 1 and EX matches rs or rt.
- Freeze condition `mem_stall`: `mem_enable` is 1 and `mem_ready` is 0.
- Outputs in RUN, priority order:
  - `mem_stall`: all six `*_ld` = 0 and `cu_mux_s` = 0.
  - Else load-use hazard: `pc_ld` = `npc_ld` = `ifid_ld` = 0; `idex_ld` = `exmem_ld` = `memwb_ld` = 1; `cu_mux_s` = 1.
  - Else all six `*_ld` = 1 and `cu_mux_s` = 0.
- Outputs in MEM_WAIT:
  - While `mem_ready` is 0: all `*_ld` = 0.
  - In the cycle `mem_ready` is 1: outputs follow the RUN rules.
- Outputs in ERROR: all `*_ld` = 0 and `cu_mux_s` = 1.
- Transitions:
  - RUN to MEM_WAIT on `mem_stall`, with `wait_cnt` set to 1.
  - MEM_WAIT to RUN when `mem_ready` is 1, with `wait_cnt` set to 0.
  - MEM_WAIT with `mem_ready` = 0: if `wait_cnt` equals MEM_TIMEOUT, go to ERROR; otherwise increment `wait_cnt`.
  - ERROR is left only by `reset`.
- `stall_count` increments by 1 on every cycle where `pc_ld` = 0 and the state is not ERROR. It saturates at 2^CNT_W − 1 and does not wrap.
- Simultaneous events: a memory stall dominates a load-use hazard. Because the pipeline is frozen, the hazard is re-evaluated on the release cycle and produces its single bubble then.
- Reset mid-stall forces RUN regardless of state.

## Timing
- While `reset` is 1 and on the first cycle after: state = RUN, `wait_cnt` = 0, `stall_count` = 0, `mem_timeout_err` = 0.
- During `reset`, all `*_ld` = 0 and `cu_mux_s` = 1.
- Load and freeze enables and `cu_mux_s` are Mealy outputs, valid in the same cycle as their cause with zero latency.
- A load-use hazard produces exactly one bubble cycle. On the next edge the load sits in MEM and the consumer gets `pa_sel`/`pb_sel` = 10.
- `mem_timeout_err` is registered. It rises on the edge entering ERROR, which is after MEM_TIMEOUT+1 consecutive not-ready cycles, and stays at 1 until reset.
- `stall_count` is registered and updates one edge after the stalled cycle.

## Test plan
- Forwarding priority: `id_rs` = 5 with EX, MEM and WB all writing r5 -> `pa_sel` = 01. Remove EX -> `pa_sel` = 10. Remove MEM -> `pa_sel` = 11. Set `id_rs` = 0 -> `pa_sel` = 00.
- Load-use: EX load to r8, `id_rt` = 8, `id_uses_rt` = 1 -> one cycle with `pc_ld` = `ifid_ld` = 0, `cu_mux_s` = 1, `idex_ld` = 1. Next cycle: all `ld` = 1, `pb_sel` = 10, `stall_count` = 1.
- Memory wait: `mem_enable` = 1 and `mem_ready` = 0 for 3 cycles, then `mem_ready` = 1 -> all `ld` = 0 for 3 cycles, released on the 4th cycle, `stall_count` = 3.
- Simultaneous: load-use present during a 2-cycle memory freeze -> 2 full-freeze cycles, then 1 bubble cycle, `stall_count` = 3.
- Timeout: MEM_TIMEOUT = 4, `mem_ready` held at 0 -> `mem_timeout_err` = 1 after 5 not-ready cycles. It stays at 1 with `ld` = 0 and `cu_mux_s` = 1 after `mem_ready` returns; `reset` clears it.
- Saturation: CNT_W = 4 with 20 stall cycles -> `stall_count` = 15. Reset mid-MEM_WAIT -> RUN, `stall_count` = 0.
